mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_arb_prio.sv | 28 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding and fetch byte enables.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      Idle   = 2'd0,
      BusyIf = 2'd1,
      BusyDm = 2'd2
   } state_e;

   localparam logic [3:0] FetchBe = 4'hF;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Priority decision between fetch and data: data first unless fetch has starved STARVE_LIMIT times.
module arb_prio
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CntW         = cnt_width(STARVE_LIMIT)
) (
   input  logic            if_req,
   input  logic            dm_req,
   input  logic [CntW-1:0] starve_cnt,
   input  logic [1:0]      excl,      // [0] fetch, [1] data: completing this cycle
   output logic            grant_if,
   output logic            grant_dm
);

   logic req_if;
   logic req_dm;
   logic starved;

   always_comb begin
      req_if   = if_req & ~excl[0];
      req_dm   = dm_req & ~excl[1];
      starved  = (starve_cnt == CntW'(STARVE_LIMIT));
      grant_dm = req_dm & ~(req_if & starved);
      grant_if = req_if & ~grant_dm;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch, data) with one outstanding transaction and a watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned STARVE_LIMIT  = 4,
   parameter int unsigned WDOG_CYCLES   = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req,
   input  logic [ADDRESS_WIDTH-1:0] if_addr,
   output logic                     if_gnt,
   output logic                     if_rvalid,
   output logic [DATA_WIDTH-1:0]    if_rdata,
   input  logic                     dm_req,
   input  logic                     dm_we,
   input  logic [ADDRESS_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0]    dm_wdata,
   input  logic [3:0]               dm_be,
   output logic                     dm_gnt,
   output logic                     dm_rvalid,
   output logic [DATA_WIDTH-1:0]    dm_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [3:0]               mem_be,
   input  logic                     mem_rvalid,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     stall_f,
   output logic                     stall_m,
   output logic                     wdog_err
);

   localparam int unsigned StarveW = cnt_width(STARVE_LIMIT);
   localparam int unsigned WdogW   = cnt_width(WDOG_CYCLES);

   state_e               state_q, state_d;
   logic [StarveW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [WdogW-1:0]     wdog_q, wdog_d;

   logic       busy;
   logic       done;
   logic       timeout;
   logic       arb_en;
   logic [1:0] excl;
   logic       grant_if;
   logic       grant_dm;
   logic       fetch_waiting;

   always_comb begin
      busy    = (state_q != Idle);
      done    = busy & mem_rvalid;
      timeout = busy & ~mem_rvalid & (wdog_q == WdogW'(WDOG_CYCLES - 1));
      // Reset gates arbitration so no grant leaks out while rst is held low.
      arb_en  = rst & ((state_q == Idle) | done);
      excl    = {(state_q == BusyDm) & mem_rvalid, (state_q == BusyIf) & mem_rvalid};
      fetch_waiting = if_req & arb_en & ~excl[0];
   end

   arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CntW         (StarveW)
   ) u_arb_prio (
      .if_req     (if_req & arb_en),
      .dm_req     (dm_req & arb_en),
      .starve_cnt (starve_cnt_q),
      .excl       (excl),
      .grant_if   (grant_if),
      .grant_dm   (grant_dm)
   );

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      wdog_d       = '0;
      if_gnt       = 1'b0;
      dm_gnt       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_be       = '0;
      if_rvalid    = 1'b0;
      if_rdata     = '0;
      dm_rvalid    = 1'b0;
      dm_rdata     = '0;

      if (grant_if) begin
         if_gnt   = 1'b1;
         mem_req  = 1'b1;
         mem_addr = if_addr;
         mem_be   = FetchBe;
      end else if (grant_dm) begin
         dm_gnt    = 1'b1;
         mem_req   = 1'b1;
         mem_we    = dm_we;
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
         mem_be    = dm_be;
      end

      if (done) begin
         if (state_q == BusyIf) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
         end else begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
         end
      end

      if (grant_if) begin
         state_d = BusyIf;
      end else if (grant_dm) begin
         state_d = BusyDm;
      end else if (done || timeout) begin
         state_d = Idle;
      end

      if (busy && !mem_rvalid && !timeout) begin
         wdog_d = wdog_q + WdogW'(1);
      end

      if (grant_if) begin
         starve_cnt_d = '0;
      end else if (grant_dm && fetch_waiting && starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + StarveW'(1);
      end
   end

   always_comb begin
      wdog_err = timeout;
      stall_f  = if_req & ~if_rvalid;
      stall_m  = dm_req & ~dm_rvalid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= Idle;
         starve_cnt_q <= '0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         wdog_q       <= wdog_d;
      end
   end

endmodule
